// File: rtl/max_q_pkg.sv
// Shared types and default sizing for the Q-value argmax/argmin search block.
package max_q_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int Q_WIDTH = 18;
   localparam int N_CELLS = 9;

endpackage

// File: rtl/max_q_cmp.sv
// Update decision for the running best: take the incoming legal sample when nothing
// is held yet, or when it strictly beats the held value in the selected direction.
module max_q_cmp #(
   parameter int WIDTH = 18
) (
   input  logic                    have_best,
   input  logic                    legal,
   input  logic                    mode_min,
   input  logic signed [WIDTH-1:0] a,
   input  logic signed [WIDTH-1:0] b,
   output logic                    take
);

   logic better;

   // Strict comparison so equal values keep the earlier (lower) index.
   always_comb begin
      better = mode_min ? (a < b) : (a > b);
      take   = legal && (!have_best || better);
   end

endmodule

// File: rtl/max_q_argmax_seq.sv
// Sequential max/min search over N_ACTIONS streamed Q-values, skipping illegal actions,
// returning the selected value and its arrival index through a valid/ready result port.
module max_q_argmax_seq
   import max_q_pkg::*;
#(
   parameter  int WIDTH     = Q_WIDTH,
   parameter  int N_ACTIONS = N_CELLS,
   localparam int IDX_W     = $clog2(N_ACTIONS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode_min,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_q,
   input  logic             in_legal,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_q,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_none,
   output logic             busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACTIONS - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] best_q, best_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;
   logic             have_best_q, have_best_d;
   logic             mode_q, mode_d;
   logic             take;
   logic             accept;

   max_q_cmp #(
      .WIDTH (WIDTH)
   ) u_cmp (
      .have_best (have_best_q),
      .legal     (in_legal),
      .mode_min  (mode_q),
      .a         ($signed(in_q)),
      .b         ($signed(best_q)),
      .take      (take)
   );

   assign accept = (state_q == SCAN) && in_valid;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      best_d      = best_q;
      best_idx_d  = best_idx_q;
      have_best_d = have_best_q;
      mode_d      = mode_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SCAN;
               mode_d      = mode_min;
               cnt_d       = '0;
               best_d      = '0;
               best_idx_d  = '0;
               have_best_d = 1'b0;
            end
         end
         SCAN: begin
            if (accept) begin
               cnt_d = cnt_q + 1'b1;
               if (take) begin
                  best_d      = in_q;
                  best_idx_d  = cnt_q;
                  have_best_d = 1'b1;
               end
               if (cnt_q == LAST_IDX) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         have_best_q <= 1'b0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         best_q      <= best_d;
         best_idx_q  <= best_idx_d;
         have_best_q <= have_best_d;
         mode_q      <= mode_d;
      end
   end

   // Result fields are gated by DONE so they read zero whenever out_valid is low.
   always_comb begin
      in_ready  = (state_q == SCAN);
      busy      = (state_q != IDLE);
      out_valid = (state_q == DONE);
      out_none  = out_valid && !have_best_q;
      out_q     = (out_valid && have_best_q) ? best_q : '0;
      out_idx   = (out_valid && have_best_q) ? best_idx_q : '0;
   end

endmodule
